// File: rtl/csa_chunk_sequencer.sv
// csa_chunk_sequencer: W-bit adder (W = N*CHUNKS) built from one shared N-bit
// carry-select slice, stepping one chunk per clock, LSB chunk first, with the
// inter-chunk carry held in a register.

// N-bit carry-select slice: low half ripples, high half is precomputed for
// both carry values and selected by the low half's carry-out.
module csa_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co
);

    generate
        if (N == 1) begin : g_single
            logic [1:0] full_s;
            assign full_s = {1'b0, a} + {1'b0, b} + {1'b0, ci};
            assign sum    = full_s[0];
            assign co     = full_s[1];
        end else begin : g_split
            localparam int LO = N / 2;
            localparam int HI = N - LO;

            logic [LO:0] lo_s;
            logic [HI:0] hi0_s;
            logic [HI:0] hi1_s;

            assign lo_s  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, ci};
            assign hi0_s = {1'b0, a[N-1:LO]} + {1'b0, b[N-1:LO]};
            assign hi1_s = hi0_s + {{HI{1'b0}}, 1'b1};

            assign sum = lo_s[LO] ? {hi1_s[HI-1:0], lo_s[LO-1:0]}
                                  : {hi0_s[HI-1:0], lo_s[LO-1:0]};
            assign co  = lo_s[LO] ? hi1_s[HI] : hi0_s[HI];
        end
    endgenerate

endmodule

module csa_chunk_sequencer #(
    parameter int N      = 4,
    parameter int CHUNKS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N*CHUNKS-1:0] a,
    input  logic [N*CHUNKS-1:0] b,
    input  logic                ci,
    output logic                busy,
    output logic                done,
    output logic [N*CHUNKS-1:0] sum,
    output logic                co
);

    localparam int W  = N * CHUNKS;
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [W-1:0]  op_a_r;
    logic [W-1:0]  op_b_r;
    logic          carry_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  sum_r;
    logic          co_r;

    logic [N-1:0]  csa_sum_s;
    logic          csa_co_s;
    logic [W-1:0]  partial_next_s;
    logic [W-1:0]  op_a_shift_s;
    logic [W-1:0]  op_b_shift_s;
    logic          last_s;
    logic          load_s;
    logic          run_s;

    csa_slice #(.N(N)) u_csa (
        op_a_r[N-1:0],
        op_b_r[N-1:0],
        carry_r,
        csa_sum_s,
        csa_co_s
    );

    assign run_s  = (state_r == RUN);
    assign last_s = run_s && (cnt_r == LAST_CNT);
    assign load_s = start && ((state_r == IDLE) || (state_r == DONE));

    generate
        if (CHUNKS == 1) begin : g_one_chunk
            // A single chunk needs no partial storage or operand shifting.
            assign partial_next_s = csa_sum_s;
            assign op_a_shift_s   = '0;
            assign op_b_shift_s   = '0;
        end else begin : g_multi_chunk
            // Only the upper W-N bits of the partial result are ever kept:
            // the newest chunk enters at the top, older chunks slide down.
            logic [W-N-1:0] partial_r;

            assign partial_next_s = {csa_sum_s, partial_r};
            assign op_a_shift_s   = {{N{1'b0}}, op_a_r[W-1:N]};
            assign op_b_shift_s   = {{N{1'b0}}, op_b_r[W-1:N]};

            // Partial result accumulation, one chunk per RUN cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    partial_r <= '0;
                end else if (run_s) begin
                    partial_r <= partial_next_s[W-1:N];
                end else begin
                    partial_r <= partial_r;
                end
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; start is only honoured outside RUN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand capture and per-chunk shifting, carry chain and chunk counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_r  <= '0;
            op_b_r  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
        end else if (load_s) begin
            op_a_r  <= a;
            op_b_r  <= b;
            carry_r <= ci;
            cnt_r   <= '0;
        end else if (run_s) begin
            op_a_r  <= op_a_shift_s;
            op_b_r  <= op_b_shift_s;
            carry_r <= csa_co_s;
            cnt_r   <= cnt_r + CW'(1'b1);
        end else begin
            op_a_r  <= op_a_r;
            op_b_r  <= op_b_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
        end
    end

    // Result registers: written only on the final chunk, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= '0;
            co_r  <= 1'b0;
        end else if (last_s) begin
            sum_r <= partial_next_s;
            co_r  <= csa_co_s;
        end else begin
            sum_r <= sum_r;
            co_r  <= co_r;
        end
    end

    assign busy = run_s;
    assign done = (state_r == DONE);
    assign sum  = sum_r;
    assign co   = co_r;

endmodule

// File: tb/tb_csa_chunk_sequencer.sv
// Self-checking bench for csa_chunk_sequencer: a 16-bit (4x4) instance, an
// exhaustive 4-bit (2x2) instance and a single-chunk 3-bit instance, checked
// against plain integer addition and the expected cycle timing.
module tb_csa_chunk_sequencer;

    localparam int N  = 4;
    localparam int CH = 4;
    localparam int W  = N * CH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         busy, done, co;
    logic [W-1:0] sum;

    logic       start2 = 1'b0;
    logic [3:0] a2 = 4'd0;
    logic [3:0] b2 = 4'd0;
    logic       ci2 = 1'b0;
    logic       busy2, done2, co2;
    logic [3:0] sum2;

    logic       start1 = 1'b0;
    logic [2:0] a1 = 3'd0;
    logic [2:0] b1 = 3'd0;
    logic       ci1 = 1'b0;
    logic       busy1, done1, co1;
    logic [2:0] sum1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_chunk_sequencer #(.N(N), .CHUNKS(CH)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .sum(sum), .co(co)
    );

    csa_chunk_sequencer #(.N(2), .CHUNKS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .ci(ci2),
        .busy(busy2), .done(done2), .sum(sum2), .co(co2)
    );

    csa_chunk_sequencer #(.N(3), .CHUNKS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .ci(ci1),
        .busy(busy1), .done(done1), .sum(sum1), .co(co1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation on the 16-bit instance and wait (bounded) for done.
    task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ici,
                          output int lat, output int bc, output logic [W-1:0] held,
                          output logic [W-1:0] s, output logic c);
        a = ia; b = ib; ci = ici; start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
        held = sum;
        lat = 0;
        bc = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) bc++;
            tick();
            lat++;
        end
        s = sum;
        c = co;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, co, sum} !== {3'b000, 16'h0000}) begin
            errors++;
            $display("FAIL reset16 busy=%b done=%b co=%b sum=%h want 0 0 0 0000", busy, done, co, sum);
        end
        checks++;
        if ({busy2, done2, co2, sum2, busy1, done1, co1, sum1} !== 13'd0) begin
            errors++;
            $display("FAIL reset_small got %b%b%b%h %b%b%b%h want all zero",
                     busy2, done2, co2, sum2, busy1, done1, co1, sum1);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_carry_ripple();
        int lat, bc;
        logic [W-1:0] held, s;
        logic c;
        launch(16'hFFFF, 16'h0001, 1'b0, lat, bc, held, s, c);
        checks++;
        if (lat !== CH) begin errors++; $display("FAIL ripple_latency got %0d want %0d", lat, CH); end
        checks++;
        if (bc !== CH) begin errors++; $display("FAIL ripple_busy_cycles got %0d want %0d", bc, CH); end
        checks++;
        if ({c, s} !== 17'h10000) begin errors++; $display("FAIL ripple_result got %b_%h want 1_0000", c, s); end
        checks++;
        if (held !== 16'h0000) begin errors++; $display("FAIL ripple_held got %h want 0000", held); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ripple_busy_in_done got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [W-1:0] held, s;
        logic c;
        launch(16'h1234, 16'h4321, 1'b1, lat, bc, held, s, c);
        checks++;
        if ({c, s} !== 17'h05556) begin errors++; $display("FAIL b2b_first got %b_%h want 0_5556", c, s); end
        // We are in the done cycle: start again immediately.
        launch(16'h8000, 16'h8000, 1'b1, lat, bc, held, s, c);
        checks++;
        if (held !== 16'h5556) begin errors++; $display("FAIL b2b_held got %h want 5556", held); end
        checks++;
        if (bc !== CH || lat !== CH) begin
            errors++; $display("FAIL b2b_timing got busy=%0d lat=%0d want %0d %0d", bc, lat, CH, CH);
        end
        checks++;
        if ({c, s} !== 17'h10001) begin errors++; $display("FAIL b2b_second got %b_%h want 1_0001", c, s); end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_start_ignored();
        logic [W-1:0] ea, eb;
        logic eci;
        logic [W:0] exp;
        int ndone, done_lat;
        logic [W:0] got;
        ea = W'($urandom); eb = W'($urandom); eci = 1'($urandom);
        exp = {1'b0, ea} + {1'b0, eb} + (W+1)'(eci);
        a = ea; b = eb; ci = eci; start = 1'b1;
        tick();
        ndone = 0;
        done_lat = -1;
        got = '0;
        for (int i = 1; i <= CH + 2; i++) begin
            start = (i < CH) ? 1'b1 : 1'b0;
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
            tick();
            if (done === 1'b1) begin
                ndone++;
                done_lat = i;
                got = {co, sum};
            end
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        checks++;
        if (done_lat !== CH) begin errors++; $display("FAIL ignore_latency got %0d want %0d", done_lat, CH); end
        checks++;
        if (got !== exp) begin errors++; $display("FAIL ignore_result got %h want %h", got, exp); end
    endtask

    task automatic test_rst_mid_run();
        int lat, bc;
        logic [W-1:0] held, s;
        logic c;
        a = 16'hABCD; b = 16'h1111; ci = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, co, sum} !== {3'b000, 16'h0000}) begin
            errors++;
            $display("FAIL rst_async busy=%b done=%b co=%b sum=%h want 0 0 0 0000", busy, done, co, sum);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_no_done got done=%b busy=%b want 0 0", done, busy);
        end
        launch(16'h00FF, 16'h0F0F, 1'b0, lat, bc, held, s, c);
        checks++;
        if ({c, s} !== 17'h0100E || lat !== CH) begin
            errors++; $display("FAIL rst_after got %b_%h lat=%0d want 0_100e lat=%0d", c, s, lat, CH);
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [W-1:0] held, s, ra, rb, prev;
        logic c, rc;
        logic [W:0] exp;
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            if (i % 5 == 0) rb = ~ra;
            exp = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
            prev = sum;
            launch(ra, rb, rc, lat, bc, held, s, c);
            checks++;
            if ({c, s} !== exp || lat !== CH || held !== prev) begin
                errors++;
                $display("FAIL random%0d a=%h b=%h ci=%b got %b_%h lat=%0d held=%h want %h lat=%0d held=%h",
                         i, ra, rb, rc, c, s, lat, held, exp, CH, prev);
            end
            if (i % 3 == 0) tick();
        end
    endtask

    task automatic test_exhaustive_2x2();
        int lat;
        logic [4:0] exp;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a2 = 4'(ia); b2 = 4'(ib); ci2 = 1'(ic); start2 = 1'b1;
                    exp = 5'(ia + ib + ic);
                    tick();
                    start2 = 1'b0;
                    lat = 0;
                    while (done2 !== 1'b1 && lat < 10) begin
                        tick();
                        lat++;
                    end
                    checks++;
                    if (done2 !== 1'b1 || lat !== 2) begin
                        errors++; $display("FAIL exh_done a=%0d b=%0d ci=%0d lat=%0d want 2", ia, ib, ic, lat);
                    end
                    checks++;
                    if ({co2, sum2} !== exp) begin
                        errors++; $display("FAIL exh_sum a=%0d b=%0d ci=%0d got %0d want %0d",
                                           ia, ib, ic, {co2, sum2}, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_single_chunk();
        a1 = 3'd7; b1 = 3'd7; ci1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            errors++; $display("FAIL one_chunk_busy got busy=%b done=%b want 1 0", busy1, done1);
        end
        tick();
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++; $display("FAIL one_chunk_done got done=%b busy=%b want 1 0", done1, busy1);
        end
        checks++;
        if ({co1, sum1} !== 4'b1111) begin
            errors++; $display("FAIL one_chunk_result got %b_%0d want 1_7", co1, sum1);
        end
        tick();
        checks++;
        if (done1 !== 1'b0) begin errors++; $display("FAIL one_chunk_pulse got done=%b want 0", done1); end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_back_to_back();
        test_start_ignored();
        test_rst_mid_run();
        test_random();
        test_exhaustive_2x2();
        test_single_chunk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
